mmio_port_uart: RTL and testbench



---
 rtl/mmio_port_pkg.sv | 23 ++
 rtl/uart_tx_serializer.sv | 84 ++++++++
 rtl/mmio_port_uart.sv | 131 +++++++++++++
 tb/tb_mmio_port_uart.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_port_pkg.sv
// Shared register offsets, STATUS bit positions and serializer state encoding
// for the MMIO port/UART peripheral.
package mmio_port_pkg;

    localparam logic [1:0] OFF_PORT_OUT = 2'd0;
    localparam logic [1:0] OFF_PORT_IN  = 2'd1;
    localparam logic [1:0] OFF_STATUS   = 2'd2;
    localparam logic [1:0] OFF_TX_DATA  = 2'd3;

    localparam int ST_FIFO_FULL   = 0;
    localparam int ST_FIFO_EMPTY  = 1;
    localparam int ST_TX_BUSY     = 2;
    localparam int ST_IN_CHANGED  = 3;
    localparam int ST_TX_OVERFLOW = 4;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } txState_t;

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer: start accepted only while idle, frame is 10*CLKS_PER_BIT cycles.
// Latency: tx drops at the edge that accepts start; no backpressure beyond busy.
module uart_tx_serializer
    import mmio_port_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       tx
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    txState_t         state, stateNext;
    logic [CNT_W-1:0] baudCnt, baudCntNext;
    logic [2:0]       bitIdx, bitIdxNext;
    logic [7:0]       shiftReg, shiftRegNext;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= TX_IDLE;
            baudCnt  <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
        end else begin
            state    <= stateNext;
            baudCnt  <= baudCntNext;
            bitIdx   <= bitIdxNext;
            shiftReg <= shiftRegNext;
        end
    end

    // tx is decoded from registered state so reset forces the line high at once
    always_comb begin
        stateNext    = state;
        baudCntNext  = baudCnt + 1'b1;
        bitIdxNext   = bitIdx;
        shiftRegNext = shiftReg;
        tx           = 1'b1;
        case (state)
            TX_IDLE: begin
                baudCntNext = '0;
                if (start) begin
                    stateNext    = TX_START;
                    shiftRegNext = data;
                end
            end
            TX_START: begin
                tx = 1'b0;
                if (baudCnt == CNT_LAST) begin
                    stateNext   = TX_DATA;
                    baudCntNext = '0;
                    bitIdxNext  = '0;
                end
            end
            TX_DATA: begin
                tx = shiftReg[0];
                if (baudCnt == CNT_LAST) begin
                    baudCntNext  = '0;
                    shiftRegNext = {1'b0, shiftReg[7:1]};
                    bitIdxNext   = bitIdx + 1'b1;
                    if (bitIdx == 3'd7) begin
                        stateNext = TX_STOP;
                    end
                end
            end
            TX_STOP: begin
                if (baudCnt == CNT_LAST) begin
                    stateNext   = TX_IDLE;
                    baudCntNext = '0;
                end
            end
            default: stateNext = TX_IDLE;
        endcase
    end

    assign busy = (state != TX_IDLE);

endmodule

// File: rtl/mmio_port_uart.sv
// MMIO window with PortOut, synchronised PortIn and a FIFO-fed UART TX.
// Latency: zero-cycle reads, writes at the edge; TX pushes while full are dropped and flagged.
module mmio_port_uart
    import mmio_port_pkg::*;
#(
    parameter logic [31:0] MMIO_BASE    = 32'h1001_0040,
    parameter int          FIFO_DEPTH   = 4,
    parameter int          CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Hit,
    input  logic [7:0]  PortIn,
    output logic [31:0] PortOut,
    output logic        UartTx
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    logic [1:0]  offset;
    logic        unusedAddrBits;
    logic        wrEn, rdEn, pushReq, portInRd, statusRd;
    logic        fifoFull, fifoEmpty, doPush, doPop, serBusy;
    logic [7:0]  sync1, sync2, prevIn;
    logic        inChanged, txOverflow;
    logic [7:0]  fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr, rdPtr;
    logic [PTR_W:0]   count;
    logic [31:0] statusWord;

    assign offset         = Address[3:2];
    assign unusedAddrBits = ^Address[1:0];
    assign Hit            = (Address[31:4] == MMIO_BASE[31:4]);
    assign wrEn           = MemWrite & Hit;
    assign rdEn           = MemRead & Hit;
    assign pushReq        = wrEn & (offset == OFF_TX_DATA);
    assign portInRd       = rdEn & (offset == OFF_PORT_IN);
    assign statusRd       = rdEn & (offset == OFF_STATUS);

    assign fifoFull  = (count == DEPTH_CNT);
    assign fifoEmpty = (count == '0);
    assign doPush    = pushReq & ~fifoFull;
    assign doPop     = ~serBusy & ~fifoEmpty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PortOut    <= '0;
            sync1      <= '0;
            sync2      <= '0;
            prevIn     <= '0;
            inChanged  <= 1'b0;
            txOverflow <= 1'b0;
            wrPtr      <= '0;
            rdPtr      <= '0;
            count      <= '0;
        end else begin
            if (wrEn && offset == OFF_PORT_OUT) begin
                PortOut <= WriteData;
            end
            sync1  <= PortIn;
            sync2  <= sync1;
            prevIn <= sync2;
            // sticky flags: a new event outranks the clearing read
            if (sync2 != prevIn) begin
                inChanged <= 1'b1;
            end else if (portInRd) begin
                inChanged <= 1'b0;
            end
            if (pushReq && fifoFull) begin
                txOverflow <= 1'b1;
            end else if (statusRd) begin
                txOverflow <= 1'b0;
            end
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // storage needs no reset: the pointers define what is valid
    always_ff @(posedge clk) begin
        if (doPush) begin
            fifoMem[wrPtr] <= WriteData[7:0];
        end
    end

    uart_tx_serializer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
        .clk   (clk),
        .reset (reset),
        .start (doPop),
        .data  (fifoMem[rdPtr]),
        .busy  (serBusy),
        .tx    (UartTx)
    );

    always_comb begin
        statusWord                 = '0;
        statusWord[ST_FIFO_FULL]   = fifoFull;
        statusWord[ST_FIFO_EMPTY]  = fifoEmpty;
        statusWord[ST_TX_BUSY]     = serBusy | ~fifoEmpty;
        statusWord[ST_IN_CHANGED]  = inChanged;
        statusWord[ST_TX_OVERFLOW] = txOverflow;
    end

    always_comb begin
        ReadData = '0;
        if (Hit) begin
            case (offset)
                OFF_PORT_OUT: ReadData = PortOut;
                OFF_PORT_IN:  ReadData = {24'd0, sync2};
                OFF_STATUS:   ReadData = statusWord;
                default:      ReadData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_port_uart.sv
// Bench for mmio_port_uart: queue/frame-schedule model checked every cycle,
// plus directed vectors with literal expectations.
module tb_mmio_port_uart;

    localparam logic [31:0] BASE  = 32'h1001_0040;
    localparam int          DEPTH = 4;
    localparam int          CPB   = 4;
    localparam int          FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic [31:0] Address = '0;
    logic [31:0] WriteData = '0;
    logic [7:0]  PortIn = '0;
    logic [31:0] ReadData;
    logic        Hit;
    logic [31:0] PortOut;
    logic        UartTx;

    mmio_port_uart #(
        .MMIO_BASE    (BASE),
        .FIFO_DEPTH   (DEPTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .Address   (Address),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Hit       (Hit),
        .PortIn    (PortIn),
        .PortOut   (PortOut),
        .UartTx    (UartTx)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int miscmp = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miscmp++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          edgeNo = 0;
    logic [31:0] mPortOut = '0;
    logic [7:0]  pinHist [3] = '{default: 8'h00};  // [0] = latest edge sample
    bit          mInChanged = 0;
    bit          mOverflow = 0;
    logic [7:0]  mQ [$];
    bit          frameValid = 0;
    int          frameStart = 0;
    logic [7:0]  frameByte = '0;

    function automatic bit inWindow(input logic [31:0] a);
        return (a >= BASE) && (a <= BASE + 32'd15);
    endfunction

    function automatic bit mFrameActive();
        return frameValid && ((edgeNo - frameStart) < FRAME);
    endfunction

    function automatic logic mTxBit();
        int k;
        if (!mFrameActive()) return 1'b1;
        k = (edgeNo - frameStart) / CPB;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return frameByte[k-1];
    endfunction

    function automatic logic [31:0] mStatus();
        logic [31:0] s;
        s = '0;
        s[0] = (mQ.size() == DEPTH);
        s[1] = (mQ.size() == 0);
        s[2] = mFrameActive() || (mQ.size() != 0);
        s[3] = mInChanged;
        s[4] = mOverflow;
        return s;
    endfunction

    function automatic logic [31:0] mRead(input logic [31:0] a);
        int off;
        if (!inWindow(a)) return 32'd0;
        off = int'((a - BASE) >> 2);
        case (off)
            0:       return mPortOut;
            1:       return {24'd0, pinHist[1]};
            2:       return mStatus();
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin : modelEdge
        bit full, idle, hit, pushReq;
        int off;
        edgeNo++;
        if (reset) begin
            mPortOut   = '0;
            pinHist    = '{default: 8'h00};
            mInChanged = 0;
            mOverflow  = 0;
            mQ.delete();
            frameValid = 0;
        end else begin
            hit     = inWindow(Address);
            off     = hit ? int'((Address - BASE) >> 2) : -1;
            full    = (mQ.size() == DEPTH);
            idle    = !frameValid || ((edgeNo - 1 - frameStart) >= FRAME);
            pushReq = MemWrite && hit && (off == 3);
            if (idle && mQ.size() != 0) begin
                frameByte  = mQ.pop_front();
                frameStart = edgeNo;
                frameValid = 1;
            end
            if (pushReq && !full) mQ.push_back(WriteData[7:0]);
            if (pushReq && full) mOverflow = 1;
            else if (MemRead && hit && off == 2) mOverflow = 0;
            if (MemWrite && hit && off == 0) mPortOut = WriteData;
            if (pinHist[1] != pinHist[2]) mInChanged = 1;
            else if (MemRead && hit && off == 1) mInChanged = 0;
            pinHist[2] = pinHist[1];
            pinHist[1] = pinHist[0];
            pinHist[0] = PortIn;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("model Hit", 32'(Hit), 32'(inWindow(Address)));
            chk("model ReadData", ReadData, mRead(Address));
            chk("model PortOut", PortOut, mPortOut);
            chk("model UartTx", 32'(UartTx), 32'(mTxBit()));
        end
    end

    // ---------------- line decoder ----------------
    logic [7:0] rxQ [$];
    bit         rxActive = 0;
    bit         rxWaitHigh = 0;
    int         rxCnt = 0;
    logic [7:0] rxShift = '0;

    always @(negedge clk) begin
        if (reset) begin
            rxActive   = 0;
            rxWaitHigh = 0;
        end else if (rxActive) begin
            rxCnt++;
            if (rxCnt >= CPB + CPB / 2 && ((rxCnt - CPB - CPB / 2) % CPB) == 0) begin
                rxShift = {UartTx, rxShift[7:1]};
                if ((rxCnt - CPB - CPB / 2) / CPB == 7) begin
                    rxQ.push_back(rxShift);
                    rxActive   = 0;
                    rxWaitHigh = 1;
                end
            end
        end else if (rxWaitHigh) begin
            if (UartTx) rxWaitHigh = 0;
        end else if (!UartTx) begin
            rxActive = 1;
            rxCnt    = 0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        Address   = a;
        WriteData = d;
        MemWrite  = 1'b1;
        MemRead   = 1'b0;
        tick();
        MemWrite  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] frameBits;
        bit done;

        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("reset PortOut", PortOut, 32'd0);
        chk("reset UartTx", 32'(UartTx), 32'd1);
        Address = BASE + 32'd8;
        #1;
        chk("reset STATUS", ReadData, 32'h0000_0002);

        // PortOut write/read and window decode
        store(BASE, 32'hDEAD_BEEF);
        chk("PortOut after store", PortOut, 32'hDEAD_BEEF);
        Address = BASE;
        MemRead = 1'b1;
        #1;
        chk("load PORT_OUT", ReadData, 32'hDEAD_BEEF);
        Address = BASE + 32'd2;
        #1;
        chk("load PORT_OUT byte addr", ReadData, 32'hDEAD_BEEF);
        Address = 32'h1001_0000;
        #1;
        chk("miss Hit", 32'(Hit), 32'd0);
        chk("miss ReadData", ReadData, 32'd0);
        Address = BASE + 32'd15;
        #1;
        chk("top of window Hit", 32'(Hit), 32'd1);
        Address = BASE + 32'd16;
        #1;
        chk("past window Hit", 32'(Hit), 32'd0);
        MemRead = 1'b0;
        tick();

        // PortIn synchroniser and change flag
        Address = BASE + 32'd4;
        PortIn  = 8'h5A;
        tick();
        chk("PortIn after 1 edge", ReadData, 32'd0);
        tick();
        tick();
        chk("PortIn after 3 edges", ReadData, 32'h0000_005A);
        Address = BASE + 32'd8;
        #1;
        chk("in_changed set", 32'(ReadData[3]), 32'd1);
        Address = BASE + 32'd4;
        MemRead = 1'b1;
        tick();
        MemRead = 1'b0;
        Address = BASE + 32'd8;
        #1;
        chk("in_changed cleared", 32'(ReadData[3]), 32'd0);

        // single frame waveform
        store(BASE + 32'd12, 32'h0000_00A5);
        Address   = BASE + 32'd8;
        frameBits = {1'b1, 8'hA5, 1'b0};
        for (int i = 1; i <= FRAME; i++) begin
            tick();
            chk($sformatf("A5 frame cycle %0d", i), 32'(UartTx), 32'(frameBits[(i - 1) / CPB]));
        end
        chk("busy in last stop cycle", 32'(ReadData[2]), 32'd1);
        tick();
        chk("busy after frame", 32'(ReadData[2]), 32'd0);

        // FIFO fill and overflow
        rxQ.delete();
        for (int i = 1; i <= 6; i++) store(BASE + 32'd12, 32'(i));
        Address = BASE + 32'd8;
        MemRead = 1'b1;
        #1;
        chk("STATUS full+overflow", ReadData, 32'h0000_0015);
        tick();
        MemRead = 1'b0;
        chk("STATUS after clear", ReadData, 32'h0000_0005);
        done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            tick();
            if (!ReadData[2]) done = 1;
        end
        chk("drain within budget", 32'(done), 32'd1);
        chk("bytes on line", 32'(rxQ.size()), 32'd5);
        if (rxQ.size() == 5) begin
            for (int i = 0; i < 5; i++) chk($sformatf("rx byte %0d", i), 32'(rxQ[i]), 32'(i + 1));
        end

        // stores to read-only offsets
        store(BASE + 32'd4, 32'hFFFF_FFFF);
        store(BASE + 32'd8, 32'hFFFF_FFFF);
        chk("RO write PortOut", PortOut, 32'hDEAD_BEEF);
        Address = BASE + 32'd8;
        #1;
        chk("RO write STATUS", ReadData, 32'h0000_0002);
        tick();
        chk("RO write no frame", 32'(UartTx), 32'd1);

        // reset in the middle of a frame
        PortIn = 8'h00;
        rxQ.delete();
        store(BASE + 32'd12, 32'h0000_0011);
        store(BASE + 32'd12, 32'h0000_0022);
        store(BASE + 32'd12, 32'h0000_0033);
        for (int i = 0; i < 16; i++) tick();
        chk("data bit 3 low", 32'(UartTx), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("async reset UartTx", 32'(UartTx), 32'd1);
        tick();
        tick();
        reset   = 1'b0;
        Address = BASE + 32'd8;
        #1;
        chk("STATUS after reset", ReadData, 32'h0000_0002);
        chk("PortOut after reset", PortOut, 32'd0);
        for (int i = 0; i < 100; i++) tick();
        chk("no frames after reset", 32'(rxQ.size()), 32'd0);
        chk("line idle after reset", 32'(UartTx), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end

endmodule
